// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer: entry layout, default widths, pointer advance.
// No logic of its own; all state lives in the users of these types.
package rob_pkg;

  localparam int ROB_DEPTH_DEF = 8;
  localparam int DATA_W_DEF    = 64;
  localparam int REG_W_DEF     = 5;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  regwrite;
    logic [REG_W_DEF-1:0]  rd;
    logic [DATA_W_DEF-1:0] data;
    logic                  mispredict;
    logic [DATA_W_DEF-1:0] target;
  } rob_entry_t;

  // depth is a power of two, so the wrap is a mask
  function automatic int unsigned rob_idx_add(input int unsigned idx, input int unsigned n,
                                              input int unsigned depth);
    return (idx + n) & (depth - 1);
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Retire selection over the COMMIT_W-entry head window: contiguous valid&done run, cut after a mispredict.
// Latency: purely combinational; no backpressure, the result is consumed in the same cycle.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = $clog2(COMMIT_W + 1),
  parameter int SLOT_W   = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
  input  rob_entry_t        win_i [COMMIT_W],
  output logic [COMMIT_W-1:0] commit_valid_o,
  output logic [CNT_W-1:0]    retire_cnt_o,
  output logic [SLOT_W-1:0]   mp_slot_o,
  output logic                flush_o
);

  logic go;

  always_comb begin
    commit_valid_o = '0;
    retire_cnt_o   = '0;
    mp_slot_o      = '0;
    flush_o        = 1'b0;
    go             = 1'b1;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (go && win_i[i].valid && win_i[i].done) begin
        commit_valid_o[i] = 1'b1;
        retire_cnt_o      = retire_cnt_o + CNT_W'(1);
        // a retiring mispredict ends the run so younger entries are squashed by the flush
        if (win_i[i].mispredict) begin
          flush_o   = 1'b1;
          mp_slot_o = SLOT_W'(i);
          go        = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order allocate, NUM_WB out-of-order writebacks, up to COMMIT_W in-order retirements.
// Latency: writeback visible to commit next cycle; alloc_ready drops when full or during a flush.
module rob_multi_commit
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_W     = REG_W_DEF,
  parameter int NUM_WB    = 2,
  parameter int COMMIT_W  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_valid,
  input  logic [REG_W-1:0]           alloc_rd,
  input  logic                       alloc_regwrite,
  output logic                       alloc_ready,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data,
  input  logic [NUM_WB-1:0]          wb_mispredict,
  input  logic [NUM_WB*DATA_W-1:0]   wb_target,
  output logic [COMMIT_W-1:0]        commit_valid,
  output logic [COMMIT_W*REG_W-1:0]  commit_rd,
  output logic [COMMIT_W-1:0]        commit_regwrite,
  output logic [COMMIT_W*DATA_W-1:0] commit_data,
  output logic                       flush,
  output logic [DATA_W-1:0]          flush_target,
  output logic                       empty,
  output logic [TAG_W:0]             count
);

  localparam int CNT_W  = $clog2(COMMIT_W + 1);
  localparam int SLOT_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

  rob_entry_t              entries_q [ROB_DEPTH];
  rob_entry_t              entries_d [ROB_DEPTH];
  logic [TAG_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]          count_q, count_d;

  rob_entry_t              win [COMMIT_W];
  logic [TAG_W-1:0]        win_idx [COMMIT_W];
  logic [CNT_W-1:0]        retire_cnt;
  logic [SLOT_W-1:0]       mp_slot;
  logic                    alloc_fire;
  logic [TAG_W-1:0]        wtag;

  always_comb begin
    for (int i = 0; i < COMMIT_W; i++) begin
      win_idx[i] = TAG_W'(rob_idx_add(32'(head_q), unsigned'(i), ROB_DEPTH));
      win[i]     = entries_q[win_idx[i]];
    end
  end

  rob_commit_select #(.COMMIT_W(COMMIT_W), .CNT_W(CNT_W), .SLOT_W(SLOT_W)) u_sel (
    .win_i          (win),
    .commit_valid_o (commit_valid),
    .retire_cnt_o   (retire_cnt),
    .mp_slot_o      (mp_slot),
    .flush_o        (flush)
  );

  // flush doubles as flush_pending: no allocation in the redirect cycle
  assign alloc_ready  = (count_q != (TAG_W+1)'(ROB_DEPTH)) && !flush;
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign alloc_tag    = tail_q;
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign flush_target = flush ? win[mp_slot].target : '0;

  always_comb begin
    commit_rd       = '0;
    commit_data     = '0;
    commit_regwrite = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      commit_rd[i*REG_W +: REG_W]    = win[i].rd;
      commit_data[i*DATA_W +: DATA_W] = win[i].data;
      commit_regwrite[i]             = win[i].regwrite && commit_valid[i];
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wtag      = '0;
    if (flush) begin
      for (int e = 0; e < ROB_DEPTH; e++) entries_d[e] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // ascending port order lets the highest port win a tag collision
      for (int p = 0; p < NUM_WB; p++) begin
        wtag = wb_tag[p*TAG_W +: TAG_W];
        if (wb_valid[p] && entries_q[wtag].valid) begin
          entries_d[wtag].data       = wb_data[p*DATA_W +: DATA_W];
          entries_d[wtag].mispredict = wb_mispredict[p];
          entries_d[wtag].target     = wb_target[p*DATA_W +: DATA_W];
          entries_d[wtag].done       = 1'b1;
        end
      end
      for (int i = 0; i < COMMIT_W; i++) begin
        if (commit_valid[i]) entries_d[win_idx[i]] = '0;
      end
      if (alloc_fire) begin
        entries_d[tail_q]          = '0;
        entries_d[tail_q].valid    = 1'b1;
        entries_d[tail_q].regwrite = alloc_regwrite;
        entries_d[tail_q].rd       = alloc_rd;
      end
      head_d  = TAG_W'(rob_idx_add(32'(head_q), 32'(retire_cnt), ROB_DEPTH));
      tail_d  = TAG_W'(rob_idx_add(32'(tail_q), 32'(alloc_fire), ROB_DEPTH));
      count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_cnt);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < ROB_DEPTH; e++) entries_q[e] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit: a vector table for the in-order/collision paths, plus
// hand-written sequences for full/wrap, mispredict flush and asynchronous reset.
module tb_rob_multi_commit;

  localparam int D = 8, TW = 3, DW = 64, RW = 5, NW = 2, CW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              alloc_valid;
  logic [RW-1:0]     alloc_rd;
  logic              alloc_regwrite;
  logic              alloc_ready;
  logic [TW-1:0]     alloc_tag;
  logic [NW-1:0]     wb_valid;
  logic [NW*TW-1:0]  wb_tag;
  logic [NW*DW-1:0]  wb_data;
  logic [NW-1:0]     wb_mispredict;
  logic [NW*DW-1:0]  wb_target;
  logic [CW-1:0]     commit_valid;
  logic [CW*RW-1:0]  commit_rd;
  logic [CW-1:0]     commit_regwrite;
  logic [CW*DW-1:0]  commit_data;
  logic              flush;
  logic [DW-1:0]     flush_target;
  logic              empty;
  logic [TW:0]       count;

  int checks = 0;
  int errors = 0;

  rob_multi_commit dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_regwrite(alloc_regwrite),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_regwrite(commit_regwrite),
    .commit_data(commit_data), .flush(flush), .flush_target(flush_target),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          a_v;
    logic [RW-1:0] a_rd;
    logic [1:0]    wv;
    logic [TW-1:0] t0, t1;
    logic [DW-1:0] d0, d1;
    logic [CW-1:0] e_cv;
    logic [TW:0]   e_cnt;
    logic [TW-1:0] e_tag;
    logic          e_empty;
    logic [RW-1:0] e_rd0;
    logic [DW-1:0] e_d0;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic a_v, input int a_rd, input logic [1:0] wv,
                              input int t0, input int t1, input logic [DW-1:0] d0,
                              input logic [DW-1:0] d1, input logic [CW-1:0] e_cv,
                              input int e_cnt, input int e_tag, input logic e_empty,
                              input int e_rd0, input logic [DW-1:0] e_d0);
    vec_t v;
    v.a_v = a_v; v.a_rd = RW'(a_rd); v.wv = wv; v.t0 = TW'(t0); v.t1 = TW'(t1);
    v.d0 = d0; v.d1 = d1; v.e_cv = e_cv; v.e_cnt = (TW+1)'(e_cnt); v.e_tag = TW'(e_tag);
    v.e_empty = e_empty; v.e_rd0 = RW'(e_rd0); v.e_d0 = e_d0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_rd = '0; alloc_regwrite = 1'b0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; wb_mispredict = '0; wb_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb2(input logic [1:0] v, input int t0, input int t1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input logic [1:0] mp, input logic [DW-1:0] tg1);
    wb_valid = v;
    wb_tag = {TW'(t1), TW'(t0)};
    wb_data = {d1, d0};
    wb_mispredict = mp;
    wb_target = {tg1, 64'h0};
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #12;
    chk("rst_cv", 64'(commit_valid), 0);
    chk("rst_flush", 64'(flush), 0);
    chk("rst_ftgt", flush_target, 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_ready", 64'(alloc_ready), 1);
    chk("rst_tag", 64'(alloc_tag), 0);
    chk("rst_count", 64'(count), 0);
    reset = 1'b0;
    tick();

    // a_v rd wv t0 t1 d0 d1 | cv cnt tag empty rd0 d0 (state after the edge)
    vecs[0]  = mk(1, 1, 2'b00, 0, 0, 0,     0,     2'b00, 1, 1, 0, 0, 0);
    vecs[1]  = mk(1, 2, 2'b00, 0, 0, 0,     0,     2'b00, 2, 2, 0, 0, 0);
    vecs[2]  = mk(1, 3, 2'b00, 0, 0, 0,     0,     2'b00, 3, 3, 0, 0, 0);
    vecs[3]  = mk(0, 0, 2'b01, 2, 0, 'h22,  0,     2'b00, 3, 3, 0, 0, 0);
    vecs[4]  = mk(0, 0, 2'b01, 1, 0, 'h11,  0,     2'b00, 3, 3, 0, 0, 0);
    vecs[5]  = mk(0, 0, 2'b01, 0, 0, 'h10,  0,     2'b11, 3, 3, 0, 1, 'h10);
    vecs[6]  = mk(0, 0, 2'b00, 0, 0, 0,     0,     2'b01, 1, 3, 0, 3, 'h22);
    vecs[7]  = mk(0, 0, 2'b00, 0, 0, 0,     0,     2'b00, 0, 3, 1, 0, 0);
    vecs[8]  = mk(0, 0, 2'b01, 6, 0, 'h66,  0,     2'b00, 0, 3, 1, 0, 0);
    vecs[9]  = mk(1, 4, 2'b00, 0, 0, 0,     0,     2'b00, 1, 4, 0, 0, 0);
    vecs[10] = mk(0, 0, 2'b11, 3, 3, 'hA,   'hB,   2'b01, 1, 4, 0, 4, 'hB);
    vecs[11] = mk(0, 0, 2'b00, 0, 0, 0,     0,     2'b00, 0, 4, 1, 0, 0);

    for (int k = 0; k < 12; k++) begin
      idle();
      alloc_valid = vecs[k].a_v;
      alloc_rd = vecs[k].a_rd;
      alloc_regwrite = vecs[k].a_v;
      wb2(vecs[k].wv, int'(vecs[k].t0), int'(vecs[k].t1), vecs[k].d0, vecs[k].d1, 2'b00, 0);
      tick();
      chk($sformatf("v%0d_cv", k), 64'(commit_valid), 64'(vecs[k].e_cv));
      chk($sformatf("v%0d_cnt", k), 64'(count), 64'(vecs[k].e_cnt));
      chk($sformatf("v%0d_tag", k), 64'(alloc_tag), 64'(vecs[k].e_tag));
      chk($sformatf("v%0d_empty", k), 64'(empty), 64'(vecs[k].e_empty));
      chk($sformatf("v%0d_flush", k), 64'(flush), 0);
      if (vecs[k].e_cv[0]) begin
        chk($sformatf("v%0d_rd0", k), 64'(commit_rd[RW-1:0]), 64'(vecs[k].e_rd0));
        chk($sformatf("v%0d_d0", k), commit_data[DW-1:0], vecs[k].e_d0);
        chk($sformatf("v%0d_rw0", k), 64'(commit_regwrite[0]), 1);
      end
    end

    // fill to full, then retire two while full: no same-cycle reuse of the freed slots
    do_reset();
    for (int i = 0; i < D; i++) begin
      idle();
      alloc_valid = 1'b1; alloc_rd = RW'(i + 1); alloc_regwrite = 1'b1;
      tick();
    end
    chk("full_count", 64'(count), 8);
    chk("full_ready", 64'(alloc_ready), 0);
    tick();
    chk("full_refuse", 64'(count), 8);
    idle();
    wb2(2'b11, 0, 1, 'h100, 'h101, 2'b00, 0);
    tick();
    chk("full_cv", 64'(commit_valid), 2'b11);
    chk("full_ready_commit", 64'(alloc_ready), 0);
    chk("full_rd1", 64'(commit_rd[2*RW-1:RW]), 2);
    idle();
    alloc_valid = 1'b1; alloc_rd = 5'd9; alloc_regwrite = 1'b1;
    tick();
    chk("full_after_cnt", 64'(count), 6);
    chk("full_after_ready", 64'(alloc_ready), 1);
    chk("full_wrap_tag", 64'(alloc_tag), 0);
    tick();
    chk("wrap_cnt", 64'(count), 7);
    chk("wrap_tag", 64'(alloc_tag), 1);

    // mispredict on tag 1: slots 0 and 1 retire, then everything younger is dropped
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      alloc_valid = 1'b1; alloc_rd = RW'(i + 1); alloc_regwrite = 1'b1;
      tick();
    end
    idle();
    wb2(2'b11, 0, 1, 'h50, 'h51, 2'b10, 'h400);
    tick();
    chk("mp_cv", 64'(commit_valid), 2'b11);
    chk("mp_flush", 64'(flush), 1);
    chk("mp_target", flush_target, 'h400);
    chk("mp_ready", 64'(alloc_ready), 0);
    idle();
    wb2(2'b11, 2, 3, 'h52, 'h53, 2'b00, 0);
    alloc_valid = 1'b1; alloc_rd = 5'd7; alloc_regwrite = 1'b1;
    tick();
    chk("mp_empty", 64'(empty), 1);
    chk("mp_count", 64'(count), 0);
    chk("mp_flush_gone", 64'(flush), 0);
    chk("mp_tag", 64'(alloc_tag), 0);
    idle();
    tick();
    chk("mp_no_commit", 64'(commit_valid), 0);

    // asynchronous reset with 5 in flight, tags 3 and 4 already done
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      alloc_valid = 1'b1; alloc_rd = RW'(i + 1); alloc_regwrite = 1'b1;
      tick();
    end
    idle();
    wb2(2'b11, 3, 4, 'h33, 'h44, 2'b00, 0);
    tick();
    chk("ar_pre_cnt", 64'(count), 5);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count", 64'(count), 0);
    chk("ar_empty", 64'(empty), 1);
    chk("ar_tag", 64'(alloc_tag), 0);
    #3;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ar_cv%0d", i), 64'(commit_valid), 0);
      chk($sformatf("ar_fl%0d", i), 64'(flush), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised reorder buffer for the out-of-order core, sitting between dispatch/rename and the architectural register file.
- Allocates one entry per cycle in program order and accepts NUM_WB out-of-order writebacks per cycle.
- Retires up to COMMIT_W completed head entries per cycle.
- Gives precise branch-mispredict recovery: the mispredicted branch commits, then a full flush.

Parameters:
- ROB_DEPTH, 8: number of entries; power of two, at least 2, and at least COMMIT_W.
- TAG_W, $clog2(ROB_DEPTH): width of an entry index (derived).
- DATA_W, 64: result and redirect-target width.
- REG_W, 5: destination register index width.
- NUM_WB, 2: number of writeback ports.
- COMMIT_W, 2: maximum retirements per cycle.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  dispatch presents an instruction.
- alloc_rd  in  REG_W  destination register.
- alloc_regwrite  in  1  instruction writes a register.
- alloc_ready  out  1  an entry is available this cycle.
- alloc_tag  out  TAG_W  tag given to the allocated entry (the current tail index).
- wb_valid  in  NUM_WB  per-port writeback strobe.
- wb_tag  in  NUM_WB*TAG_W  per-port tag.
- wb_data  in  NUM_WB*DATA_W  per-port result.
- wb_mispredict  in  NUM_WB  entry is a mispredicted branch.
- wb_target  in  NUM_WB*DATA_W  correct PC for a mispredict.
- commit_valid  out  COMMIT_W  slot i retires this cycle; the set bits are contiguous from slot 0.
- commit_rd  out  COMMIT_W*REG_W  destination per slot.
- commit_regwrite  out  COMMIT_W  register-file write enable per slot.
- commit_data  out  COMMIT_W*DATA_W  result per slot.
- flush  out  1  one-cycle redirect pulse.
- flush_target  out  DATA_W  redirect PC; valid when flush is high.
- empty  out  1  no valid entries.
- count  out  TAG_W+1  occupancy.

Behaviour:
- Reset, asynchronous:
  - head=0, tail=0, count=0, all entry valid/done/mispredict bits cleared.
  - Combinational outputs then settle to: commit_valid=0, flush=0, flush_target=0, empty=1, alloc_ready=1, alloc_tag=0.
- Entry fields: valid, done, regwrite, rd, data, mispredict, target.
- Allocation:
  - alloc_ready = (count != ROB_DEPTH) && !flush_pending.
  - The decision uses count at the start of the cycle; no same-cycle bypass from commits.
  - On alloc_valid && alloc_ready: entry[tail] is written with valid=1, done=0; tail advances and wraps modulo ROB_DEPTH.
  - alloc_tag is the tail index before the increment.
- Writeback:
  - On wb_valid[p] with entry[wb_tag[p]].valid: write data, mispredict and target, and set done=1.
  - A writeback to an invalid entry is ignored.
  - Two ports hitting the same tag in one cycle: the highest port index wins.
  - Done becomes visible to commit the following cycle; there is no writeback-to-commit bypass.
- Commit (combinational select, registered state update):
  - Slot i retires iff entries head..head+i are all valid && done.
  - Slot i also requires that no earlier slot in the same cycle is a mispredict.
  - Retired entries are cleared; head advances by the number retired, modulo ROB_DEPTH.
  - count updates as count + alloc − retired, in the same cycle.
- Mispredict:
  - When a retiring slot has mispredict=1, it is the last slot retired that cycle.
  - flush and flush_target come from that entry in the same cycle it commits.
  - flush_pending is a combinational term equal to flush.
  - On the next edge, all entries are invalidated, head=tail=0 and count=0.
  - Any allocation attempted in the flush cycle is refused (alloc_ready=0).
  - Writebacks in the flush cycle are discarded.
- Full/empty boundaries:
  - Full (count=ROB_DEPTH): alloc_ready=0 even if commits occur that cycle.
  - Empty: commit_valid=0; alloc, then writeback, then commit takes a minimum of 2 cycles after allocation.
- Pointer wrap: head and tail are TAG_W bits and wrap naturally; full/empty are distinguished by count only.
- Reset mid-operation: all state is dropped immediately and asynchronously; no flush pulse is generated.

Decomposition:
- Shared package rob_pkg holds:
  - rob_entry_t struct (valid, done, regwrite, rd, data, mispredict, target);
  - the ROB_DEPTH / DATA_W / REG_W defaults;
  - the function rob_idx_add(idx, n) for modulo advance.
- Sub-module rob_commit_select, purely combinational: takes the head window of COMMIT_W entries and produces commit_valid, the retire count, the mispredict-slot index and the flush signal.
- The top level holds the storage array, the pointers and the writeback logic.

Test Plan:
- Reset, then allocate 3 (rd=1,2,3), write back tags 2,1,0 on successive cycles:
  - commit_valid stays 0 until tag 0 is done;
  - the next cycle commits rd1, rd2 together (commit_valid=2'b11);
  - the following cycle commits rd3;
  - count ends at 0.
- Allocate 8 entries with no writebacks:
  - alloc_ready=0 and count=8 after the 8th;
  - complete tag 0 and tag 1 together: both retire in one cycle;
  - alloc_ready=1 the cycle after;
  - the next alloc_tag is 0 (wrap).
- Allocate 4; write back tag1 with mispredict=1, target=0x400, plus tags 0, 2, 3:
  - slots 0 and 1 retire;
  - flush=1, flush_target=0x400;
  - next cycle empty=1, count=0;
  - tags 2 and 3 never commit.
- Same-cycle collision: wb port0 and port1 both hit tag 0 with data 0xA and 0xB → commit_data=0xB.
- Assert reset while 5 entries are in flight and 2 are done:
  - immediate count=0, empty=1;
  - no commit_valid or flush afterward;
  - alloc_tag=0.
- Writeback to an unallocated tag 6 → no state change, count unchanged, no commit.
